// File: rtl/scan_decoder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scan_decoder_pkg : FSM state encoding and one-hot decode helper
// Rev 1.0
// ----------------------------------------------------------------------------
package scan_decoder_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  // Widest select the decode helper supports; callers truncate to their width.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT   = 2 ** MAX_SEL_W;

  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                input int                   num_out);
    logic [MAX_OUT-1:0] r;
    r = '0;
    if (32'(sel) < num_out) r[sel] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_decoder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scan_decoder_if : control inputs and decoded outputs of scan_decoder
// Rev 1.0
// ----------------------------------------------------------------------------
interface scan_decoder_if #(
  parameter int SEL_W = 2
);
  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic               load;
  logic [2**SEL_W-1:0] dout;
  logic [SEL_W-1:0]   idx;
  logic               valid;
  logic               wrap;

  modport master (output en, mode, sel, load, input dout, idx, valid, wrap);
  modport slave  (input en, mode, sel, load, output dout, idx, valid, wrap);
endinterface
`default_nettype wire

// File: rtl/scan_decoder_prescaler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scan_prescaler : divides clk by PRESCALE, tick on the last count
// Rev 1.0
// ----------------------------------------------------------------------------
module scan_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_last;

  assign w_last = (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = w_last ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A clearing cycle never ticks, so load/entry always restart a full step.
  assign tick = en && !clr && w_last;

endmodule
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scan_decoder : registered one-hot decoder with direct select and auto-scan
// Rev 1.0
// ----------------------------------------------------------------------------
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int NUM_OUT  = 2 ** SEL_W,
  parameter int PRESCALE = 4
) (
  input  logic           clk,
  input  logic           rst,
  scan_decoder_if.slave  bus
);

  localparam int NOUT_W = 2 ** SEL_W;

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [NOUT_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  logic w_scan_stay, w_load, w_pre_clr, w_tick;
  logic w_sel_ok, w_idx_ok, w_idx_last;

  always_comb begin
    state_d = ST_IDLE;
    if (bus.en) state_d = bus.mode ? ST_SCAN : ST_DIRECT;
  end

  assign w_scan_stay = (state_d == ST_SCAN) && (state_q == ST_SCAN);
  assign w_load      = (state_d == ST_SCAN) && bus.load;
  assign w_pre_clr   = !w_scan_stay || w_load;
  assign w_sel_ok    = 32'(bus.sel) < NUM_OUT;
  assign w_idx_ok    = 32'(idx_q) < NUM_OUT;
  assign w_idx_last  = 32'(idx_q) == NUM_OUT - 1;

  scan_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_pre_clr),
    .en   (w_scan_stay),
    .tick (w_tick)
  );

  // Outputs are decoded from the next index so dout and idx change together.
  always_comb begin
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    dout_d  = '0;
    case (state_d)
      ST_DIRECT: begin
        idx_d  = bus.sel;
        dout_d = NOUT_W'(onehot(MAX_SEL_W'(idx_d), NUM_OUT));
      end
      ST_SCAN: begin
        if (w_load) begin
          idx_d = w_sel_ok ? bus.sel : '0;
        end else if (state_q != ST_SCAN) begin
          idx_d = w_idx_ok ? idx_q : '0;
        end else if (w_tick) begin
          if (w_idx_last) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        dout_d = NOUT_W'(onehot(MAX_SEL_W'(idx_d), NUM_OUT));
      end
      default: ;
    endcase
    valid_d = |dout_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_scan_decoder : NUM_OUT=4 and NUM_OUT=3 decoders checked against a model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_scan_decoder;

  localparam int PRESCALE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1, mode = 1'b1, load = 1'b0;
  logic [1:0] sel = 2'd0;

  int total = 0;
  int bad   = 0;

  // Model state per DUT: [0] = NUM_OUT 4, [1] = NUM_OUT 3
  int         c_no  [2] = '{4, 3};
  int         m_idx [2];
  int         m_cnt [2];
  bit         m_in  [2];
  logic [3:0] m_dout[2];
  logic       m_valid[2];
  logic       m_wrap [2];

  scan_decoder_if #(.SEL_W(2)) if4 ();
  scan_decoder_if #(.SEL_W(2)) if3 ();

  assign if4.en = en;  assign if4.mode = mode;  assign if4.sel = sel;  assign if4.load = load;
  assign if3.en = en;  assign if3.mode = mode;  assign if3.sel = sel;  assign if3.load = load;

  scan_decoder #(.SEL_W(2), .NUM_OUT(4), .PRESCALE(PRESCALE)) u_dut4 (
    .clk (clk), .rst (rst), .bus (if4.slave));
  scan_decoder #(.SEL_W(2), .NUM_OUT(3), .PRESCALE(PRESCALE)) u_dut3 (
    .clk (clk), .rst (rst), .bus (if3.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behaviour counted in clocks since the last step, load or entry into SCAN.
  task automatic model_edge(input int k);
    m_wrap[k] = 1'b0;
    if (rst) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_in[k] = 1'b0;
      m_dout[k] = '0; m_valid[k] = 1'b0;
    end else if (!en) begin
      m_in[k] = 1'b0; m_cnt[k] = 0;
      m_dout[k] = '0; m_valid[k] = 1'b0;
    end else if (!mode) begin
      m_in[k] = 1'b0; m_cnt[k] = 0;
      m_idx[k] = int'(sel);
      m_valid[k] = (m_idx[k] < c_no[k]);
      m_dout[k] = m_valid[k] ? 4'(1 << m_idx[k]) : 4'd0;
    end else begin
      if (load) begin
        m_idx[k] = (int'(sel) < c_no[k]) ? int'(sel) : 0;
        m_cnt[k] = 0;
      end else if (!m_in[k]) begin
        if (m_idx[k] >= c_no[k]) m_idx[k] = 0;
        m_cnt[k] = 0;
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] == PRESCALE) begin
          m_cnt[k] = 0;
          if (m_idx[k] == c_no[k] - 1) begin
            m_idx[k]  = 0;
            m_wrap[k] = 1'b1;
          end else begin
            m_idx[k]++;
          end
        end
      end
      m_in[k]    = 1'b1;
      m_valid[k] = 1'b1;
      m_dout[k]  = 4'(1 << m_idx[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    chk("dout4",  32'(if4.dout),  32'(m_dout[0]));
    chk("idx4",   32'(if4.idx),   32'(m_idx[0]));
    chk("valid4", 32'(if4.valid), 32'(m_valid[0]));
    chk("wrap4",  32'(if4.wrap),  32'(m_wrap[0]));
    chk("dout3",  32'(if3.dout),  32'(m_dout[1]));
    chk("idx3",   32'(if3.idx),   32'(m_idx[1]));
    chk("valid3", 32'(if3.valid), 32'(m_valid[1]));
    chk("wrap3",  32'(if3.wrap),  32'(m_wrap[1]));
  endtask

  initial begin
    int wraps;
    // Reset wins over an enabled scan request
    rst = 1'b1; en = 1'b1; mode = 1'b1;
    step(); step();
    chk("rst_dout", 32'(if4.dout), 32'd0);
    chk("rst_idx",  32'(if4.idx),  32'd0);

    // DIRECT walk over every select, including out-of-range for NUM_OUT=3
    rst = 1'b0; mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
    end
    chk("dir3_sel3_dout", 32'(if3.dout), 32'd0);
    chk("dir4_sel3_dout", 32'(if4.dout), 32'b1000);

    // SCAN from idx 0 across a full wrap on both decoders
    sel = 2'd0; step();
    mode = 1'b1;
    wraps = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (if4.wrap) wraps++;
    end
    chk("scan4_wraps", 32'(wraps), 32'd1);

    // Load one cycle ahead of a pending tick
    step(); step();
    sel = 2'd2; load = 1'b1; step();
    load = 1'b0; sel = 2'd0;
    for (int i = 0; i < 7; i++) step();

    // Drop enable mid-scan at idx 1, then re-enter SCAN
    sel = 2'd1; load = 1'b1; step();
    load = 1'b0; step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_dout", 32'(if4.dout), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Load ignored outside SCAN; DIRECT sel=3 then SCAN clamps NUM_OUT=3 to 0
    mode = 1'b0; sel = 2'd3; load = 1'b1; step();
    load = 1'b0; mode = 1'b1; step();
    chk("clamp3_idx", 32'(if3.idx), 32'd0);
    step(); step();

    // Reset mid-scan
    rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      load = ($urandom_range(0, 7) == 0);
      sel  = 2'($urandom_range(0, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
